// File: rtl/minesweeper_pkg.sv
// Shared constants and seven-segment helpers for the minesweeper timer/score path.
// The SEG7 decoders are used only when MINESWEEPER_TIMER_SEG7_EN is defined.
package minesweeper_pkg;
  localparam int          BCD_W     = 12;
  localparam logic [11:0] BCD_MAX   = 12'h999;
  localparam logic [11:0] BEST_INIT = 12'h999;

  // Active-low segments ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG7_DASH = 7'h3F;
  localparam logic [6:0] SEG7_OFF  = 7'h7F;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    s = SEG7_OFF;
    unique case (d)
      4'd0: s = 7'h40;
      4'd1: s = 7'h79;
      4'd2: s = 7'h24;
      4'd3: s = 7'h30;
      4'd4: s = 7'h19;
      4'd5: s = 7'h12;
      4'd6: s = 7'h02;
      4'd7: s = 7'h78;
      4'd8: s = 7'h00;
      4'd9: s = 7'h10;
      default: s = SEG7_OFF;
    endcase
    return s;
  endfunction

  function automatic logic [20:0] seg7_bcd3(input logic [11:0] v);
    return {seg7(v[11:8]), seg7(v[7:4]), seg7(v[3:0])};
  endfunction
endpackage

// File: rtl/game_timer_score_bcd_counter3.sv
// Three-digit BCD up-counter that saturates at 999.
// clr_i has priority over inc_i; sat_o is registered alongside the value.
module bcd_counter3
  import minesweeper_pkg::*;
(
  input  logic              clk,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [BCD_W-1:0]  val_o,
  output logic              sat_o
);
  logic [BCD_W-1:0] val_q, val_d;
  logic             sat_q;

  always_comb begin
    val_d = val_q;
    if (clr_i) begin
      val_d = '0;
    end else if (inc_i && val_q != BCD_MAX) begin
      if (val_q[3:0] != 4'd9) begin
        val_d[3:0] = val_q[3:0] + 4'd1;
      end else begin
        val_d[3:0] = 4'd0;
        if (val_q[7:4] != 4'd9) begin
          val_d[7:4] = val_q[7:4] + 4'd1;
        end else begin
          val_d[7:4]  = 4'd0;
          val_d[11:8] = val_q[11:8] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    val_q <= val_d;
    sat_q <= (val_d == BCD_MAX);
  end

  assign val_o = val_q;
  assign sat_o = sat_q;
endmodule

// File: rtl/game_timer_score.sv
// Elapsed-time counter and best-time keeper for the minesweeper HUD.
// Optional feature macro: MINESWEEPER_TIMER_SEG7_EN adds registered 7-seg outputs.
module game_timer_score
  import minesweeper_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int PRESC_W = 26
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic              clear_n,
  input  logic              clock_run,
  input  logic              compare_high_score,
  output logic              tick,
  output logic [BCD_W-1:0]  time_bcd,
  output logic              time_sat,
  output logic [BCD_W-1:0]  best_bcd,
  output logic              best_valid,
`ifdef MINESWEEPER_TIMER_SEG7_EN
  output logic [20:0]       hex_time,
  output logic [20:0]       hex_best,
`endif
  output logic              new_record
);
  localparam logic [PRESC_W-1:0] TERM = PRESC_W'(CLK_HZ - 1);

  logic [PRESC_W-1:0] presc_q;
  logic               tick_q;
  logic               cmp_q;
  logic [BCD_W-1:0]   best_q;
  logic               best_valid_q;
  logic               new_rec_q;
  logic [BCD_W-1:0]   time_q;
  logic               sat_q;
  logic               cnt_clr;
  logic               cnt_inc;
  logic               cmp_evt;

  assign cnt_clr = reset_in | ~clear_n;
  assign cnt_inc = clock_run & (presc_q == TERM);
  // Compare sees the pre-increment time since time_q updates on this same edge
  assign cmp_evt = compare_high_score & ~cmp_q;

  bcd_counter3 u_cnt (
    .clk   (clk),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .val_o (time_q),
    .sat_o (sat_q)
  );

  always_ff @(posedge clk) begin
    if (reset_in) begin
      presc_q      <= '0;
      tick_q       <= 1'b0;
      cmp_q        <= 1'b0;
      best_q       <= BEST_INIT;
      best_valid_q <= 1'b0;
      new_rec_q    <= 1'b0;
    end else if (!clear_n) begin
      presc_q   <= '0;
      tick_q    <= 1'b0;
      cmp_q     <= 1'b0;
      new_rec_q <= 1'b0;
    end else begin
      cmp_q  <= compare_high_score;
      tick_q <= cnt_inc;
      if (clock_run)
        presc_q <= cnt_inc ? '0 : presc_q + 1'b1;
      if (cmp_evt && (!best_valid_q || time_q < best_q)) begin
        best_q       <= time_q;
        best_valid_q <= 1'b1;
        new_rec_q    <= 1'b1;
      end
    end
  end

`ifdef MINESWEEPER_TIMER_SEG7_EN
  logic [20:0] hex_time_q;
  logic [20:0] hex_best_q;

  always_ff @(posedge clk) begin
    hex_time_q <= seg7_bcd3(time_q);
    hex_best_q <= best_valid_q ? seg7_bcd3(best_q)
                               : {3{SEG7_DASH}};
  end

  assign hex_time = hex_time_q;
  assign hex_best = hex_best_q;
`endif

  assign tick       = tick_q;
  assign time_bcd   = time_q;
  assign time_sat   = sat_q;
  assign best_bcd   = best_q;
  assign best_valid = best_valid_q;
  assign new_record = new_rec_q;
endmodule

// File: tb/tb_game_timer_score.sv
// Directed bench for game_timer_score with a 4-cycle second.
// Inputs are driven and outputs checked 1ns after each rising edge.
module tb_game_timer_score;
  logic        clk = 1'b0;
  logic        reset_in;
  logic        clear_n;
  logic        clock_run;
  logic        compare_high_score;
  logic        tick;
  logic [11:0] time_bcd;
  logic        time_sat;
  logic [11:0] best_bcd;
  logic        best_valid;
  logic        new_record;
`ifdef MINESWEEPER_TIMER_SEG7_EN
  logic [20:0] hex_time;
  logic [20:0] hex_best;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  game_timer_score #(.CLK_HZ(4), .PRESC_W(2)) dut (
    .clk                (clk),
    .reset_in           (reset_in),
    .clear_n            (clear_n),
    .clock_run          (clock_run),
    .compare_high_score (compare_high_score),
    .tick               (tick),
    .time_bcd           (time_bcd),
    .time_sat           (time_sat),
    .best_bcd           (best_bcd),
    .best_valid         (best_valid),
`ifdef MINESWEEPER_TIMER_SEG7_EN
    .hex_time           (hex_time),
    .hex_best           (hex_best),
`endif
    .new_record         (new_record)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs,
                     input logic [11:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic round_clear();
    clear_n = 1'b0;
    cyc(1);
    clear_n = 1'b1;
  endtask

  task automatic win_at(input int secs);
    clock_run = 1'b1;
    cyc(4 * secs);
    clock_run = 1'b0;
    compare_high_score = 1'b1;
    cyc(3);
    compare_high_score = 1'b0;
    cyc(1);
  endtask

  initial begin
    reset_in = 1'b1;
    clear_n = 1'b0;
    clock_run = 1'b0;
    compare_high_score = 1'b0;
    cyc(2);
    chk("rst_time", time_bcd, 12'h000);
    chk("rst_best", best_bcd, 12'h999);
    chk("rst_valid", {11'd0, best_valid}, 12'h000);
    chk("rst_newrec", {11'd0, new_record}, 12'h000);
    chk("rst_tick", {11'd0, tick}, 12'h000);
    chk("rst_sat", {11'd0, time_sat}, 12'h000);

    reset_in = 1'b0;
    clear_n = 1'b1;
    clock_run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      chk("run_tick", {11'd0, tick}, {11'd0, (i % 4) == 3});
      if (i == 35) chk("run_009", time_bcd, 12'h009);
    end
    chk("run_010", time_bcd, 12'h010);

    clock_run = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      chk("pause_tick", {11'd0, tick}, 12'h000);
    end
    chk("pause_time", time_bcd, 12'h010);

    clock_run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("resume_tick", {11'd0, tick}, {11'd0, i == 3});
    end
    chk("resume_time", time_bcd, 12'h011);

    win_at(14);
    chk("win1_time", time_bcd, 12'h025);
    compare_high_score = 1'b1;
    cyc(10);
    compare_high_score = 1'b0;
    chk("win1_best", best_bcd, 12'h025);
    chk("win1_valid", {11'd0, best_valid}, 12'h001);
    chk("win1_newrec", {11'd0, new_record}, 12'h001);

    round_clear();
    chk("clr_time", time_bcd, 12'h000);
    chk("clr_newrec", {11'd0, new_record}, 12'h000);
    chk("clr_best", best_bcd, 12'h025);
    chk("clr_valid", {11'd0, best_valid}, 12'h001);

    win_at(30);
    chk("win2_time", time_bcd, 12'h030);
    chk("win2_best", best_bcd, 12'h025);
    chk("win2_newrec", {11'd0, new_record}, 12'h000);

    round_clear();
    win_at(25);
    chk("win3_best", best_bcd, 12'h025);
    chk("win3_newrec", {11'd0, new_record}, 12'h000);

    round_clear();
    win_at(12);
    chk("win4_best", best_bcd, 12'h012);
    chk("win4_newrec", {11'd0, new_record}, 12'h001);

    round_clear();
    clock_run = 1'b1;
    cyc(6);
    chk("mid_time", time_bcd, 12'h001);
    reset_in = 1'b1;
    cyc(1);
    reset_in = 1'b0;
    clock_run = 1'b0;
    chk("rst2_best", best_bcd, 12'h999);
    chk("rst2_valid", {11'd0, best_valid}, 12'h000);
    chk("rst2_time", time_bcd, 12'h000);
    chk("rst2_tick", {11'd0, tick}, 12'h000);

    clear_n = 1'b0;
    clock_run = 1'b1;
    cyc(8);
    chk("clrrun_time", time_bcd, 12'h000);
    chk("clrrun_tick", {11'd0, tick}, 12'h000);
    clear_n = 1'b1;

    cyc(4 * 998);
    chk("sat_998", time_bcd, 12'h998);
    chk("sat_998_flag", {11'd0, time_sat}, 12'h000);
    cyc(4);
    chk("sat_999", time_bcd, 12'h999);
    chk("sat_flag", {11'd0, time_sat}, 12'h001);
    chk("sat_tick", {11'd0, tick}, 12'h001);
    cyc(3);
    chk("sat_gap", {11'd0, tick}, 12'h000);
    cyc(1);
    chk("sat_tick2", {11'd0, tick}, 12'h001);
    chk("sat_hold", time_bcd, 12'h999);
    clock_run = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
